// File: rtl/nn_argmax_reader.sv
// nn_argmax_reader: streams per-class signed scores and reports the argmax digit on a held result handshake
module nn_argmax_reader #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 32,
   parameter int IDX_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              score_valid,
   output logic              score_ready,
   input  logic [DATA_W-1:0] score_data,
   input  logic              score_last,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [IDX_W-1:0]  result_digit,
   output logic [DATA_W-1:0] result_score,
   output logic              result_err
);
   typedef enum logic {SCAN, DONE} state_t;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_count, r_idx, r_res_digit, w_idx_nxt;
   logic signed [DATA_W-1:0]  r_max, r_res_score, w_max_nxt;
   logic                      r_res_err;
   logic                      w_accept, w_first, w_gt, w_full, w_end, w_err;
   assign score_ready  = (r_state == SCAN) & ~rst;
   assign w_accept     = score_valid & score_ready;
   assign w_first      = r_count == '0;
   assign w_gt         = $signed(score_data) > r_max;
   assign w_full       = r_count == LAST_IDX;
   assign w_end        = w_accept & (score_last | w_full);
   // Any disagreement between the last flag and the beat count is a length error
   assign w_err        = score_last != w_full;
   assign w_max_nxt    = (w_first | w_gt) ? $signed(score_data) : r_max;
   assign w_idx_nxt    = w_first ? '0 : (w_gt ? r_count : r_idx);
   assign result_valid = r_state == DONE;
   assign result_digit = r_res_digit;
   assign result_score = r_res_score;
   assign result_err   = r_res_err;
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == SCAN && w_end) w_state_nxt = DONE;
      if (r_state == DONE && result_ready) w_state_nxt = SCAN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SCAN;
         r_count     <= '0;
         r_idx       <= '0;
         r_max       <= '0;
         r_res_digit <= '0;
         r_res_score <= '0;
         r_res_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_count <= w_end ? '0 : r_count + IDX_W'(1);
            r_max   <= w_max_nxt;
            r_idx   <= w_idx_nxt;
         end
         // Result registers are separate so they stay put while the next frame scans
         if (w_end) begin
            r_res_digit <= w_idx_nxt;
            r_res_score <= w_max_nxt;
            r_res_err   <= w_err;
         end
      end
   end
endmodule

// File: tb/tb_nn_argmax_reader.sv
// tb_nn_argmax_reader: directed frames with a result scoreboard and direct handshake/timing checks
module tb_nn_argmax_reader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        score_valid = 1'b0;
   logic        score_ready;
   logic [31:0] score_data = '0;
   logic        score_last = 1'b0;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic [3:0]  result_digit;
   logic [31:0] result_score;
   logic        result_err;

   typedef struct packed {
      logic [3:0]  digit;
      logic [31:0] score;
      logic        err;
   } res_t;

   res_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   nn_argmax_reader dut (
      .clk(clk), .rst(rst),
      .score_valid(score_valid), .score_ready(score_ready),
      .score_data(score_data), .score_last(score_last),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_digit(result_digit), .result_score(result_score),
      .result_err(result_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && result_valid && result_ready) begin
         res_t e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got digit=%0d score=%0h err=%0b expected no result", result_digit, result_score, result_err);
         end else begin
            e = exp_q.pop_front();
            if ({result_digit, result_score, result_err} !== e) begin
               bad++;
               $display("FAIL sb_result: got digit=%0d score=%0h err=%0b expected digit=%0d score=%0h err=%0b",
                        result_digit, result_score, result_err, e.digit, e.score, e.err);
            end
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic last);
      int t = 0;
      @(negedge clk);
      while (!score_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!score_ready) check("ready_timeout", 32'(score_ready), 32'd1);
      score_valid = 1'b1;
      score_data  = d;
      score_last  = last;
      @(posedge clk);
      #1;
      score_valid = 1'b0;
      score_data  = 32'h7fff_ffff;
      score_last  = 1'b1;
   endtask

   task automatic send_frame(input string name, input int s[10], input int n, input logic use_last,
                             input logic [3:0] dg, input logic [31:0] sc, input logic er);
      exp_q.push_back({dg, sc, er});
      for (int i = 0; i < n; i++) send_beat(s[i], use_last && i == n - 1);
      @(negedge clk);
      check({name, "_latency"}, 32'(result_valid), 32'd1);
      check({name, "_ready_low"}, 32'(score_ready), 32'd0);
      if (result_ready) begin
         @(negedge clk);
         check({name, "_release_valid"}, 32'(result_valid), 32'd0);
         check({name, "_release_ready"}, 32'(score_ready), 32'd1);
      end
   endtask

   int f1[10] = '{3, -1, 0, 8, 2, 5, 1, 9, -7, 4};
   int f2[10] = '{0, 1, 6, -2, 3, 6, 0, 0, 0, 0};
   int f3[10] = '{-4, -5, -6, -7, -8, -9, -10, -11, -12, -13};
   int f4[10] = '{1, -2, -3, -4, 0, 0, 0, 0, 0, 0};
   int f5[10] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
   int f6[10] = '{0, 1, 2, 3, 42, 5, 6, 7, 8, 9};

   initial begin
      repeat (2) @(negedge clk);
      check("rst_score_ready", 32'(score_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_digit", 32'(result_digit), 32'd0);
      check("reset_score", result_score, 32'd0);
      check("reset_err", 32'(result_err), 32'd0);
      check("reset_ready", 32'(score_ready), 32'd1);

      send_frame("mixed", f1, 10, 1'b1, 4'd7, 32'd9, 1'b0);
      send_frame("tie", f2, 10, 1'b1, 4'd2, 32'd6, 1'b0);
      send_frame("negative", f3, 10, 1'b1, 4'd0, 32'hffff_fffc, 1'b0);
      send_frame("short", f4, 4, 1'b1, 4'd0, 32'd1, 1'b1);
      send_frame("long", f5, 10, 1'b0, 4'd9, 32'd14, 1'b1);

      result_ready = 1'b0;
      send_frame("hold", f2, 10, 1'b1, 4'd2, 32'd6, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(result_valid), 32'd1);
         check("hold_ready", 32'(score_ready), 32'd0);
         check("hold_digit", 32'(result_digit), 32'd2);
         check("hold_score", result_score, 32'd6);
         check("hold_err", 32'(result_err), 32'd0);
      end
      @(posedge clk);
      #1 result_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_release_valid", 32'(result_valid), 32'd0);
      check("hold_release_ready", 32'(score_ready), 32'd1);
      check("retain_digit", 32'(result_digit), 32'd2);

      send_beat(32'd100, 1'b0);
      send_beat(32'd200, 1'b0);
      send_beat(32'd300, 1'b0);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(score_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(result_valid), 32'd0);
      check("midrst_digit", 32'(result_digit), 32'd0);
      check("midrst_score", result_score, 32'd0);
      check("midrst_ready_after", 32'(score_ready), 32'd1);
      send_frame("clean", f6, 10, 1'b1, 4'd4, 32'd42, 1'b0);

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
